// File: rtl/mkmif_pkg.sv
// Shared constants and state encoding for the MKM serial SRAM slave.
package mkmif_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    RD_STAT,
    WR_STAT,
    IGNORE
  } state_t;

endpackage

// File: rtl/mkmif_spi_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives edge events.
module mkmif_spi_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_di,
  output logic di_s,
  output logic cs_n_s,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic cs_fall_c,
  output logic cs_rise_c
);

  logic sclk_meta, sclk_s, sclk_q;
  logic cs_meta, cs_q;
  logic di_meta;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_meta   <= 1'b1;
      cs_n_s    <= 1'b1;
      cs_q      <= 1'b1;
      di_meta   <= 1'b0;
      di_s      <= 1'b0;
    end else begin
      sclk_meta <= spi_sclk;
      sclk_s    <= sclk_meta;
      sclk_q    <= sclk_s;
      cs_meta   <= spi_cs_n;
      cs_n_s    <= cs_meta;
      cs_q      <= cs_n_s;
      di_meta   <= spi_di;
      di_s      <= di_meta;
    end
  end

  // Single-cycle edge events from the synchronized levels.
  assign sclk_rise_c = sclk_s & ~sclk_q;
  assign sclk_fall_c = ~sclk_s & sclk_q;
  assign cs_fall_c   = ~cs_n_s & cs_q;
  assign cs_rise_c   = cs_n_s & ~cs_q;

endmodule

// File: rtl/mkmif_sram_slave.sv
// SPI mode-0 slave emulating a 23K640 serial SRAM (READ/WRITE/RDSR/WRSR).
module mkmif_sram_slave
  import mkmif_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 13,
  parameter int unsigned PAGE_BITS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_di,
  output logic       spi_do,
  output logic [7:0] status,
  output logic       active,
  output logic       cmd_error
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(15);

  logic di_s, cs_n_s, sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

  mkmif_spi_sync u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_di      (spi_di),
    .di_s        (di_s),
    .cs_n_s      (cs_n_s),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c),
    .cs_fall_c   (cs_fall_c),
    .cs_rise_c   (cs_rise_c)
  );

  state_t               state, state_d;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [ADDR_BITS-2:0] rx, rx_d;
  logic [ADDR_BITS-1:0] rx_n_c;
  logic [7:0]           tx, tx_d;
  logic [ADDR_BITS-1:0] addr, addr_d, addr_inc_c, mem_addr_c;
  logic [7:0]           status_d;
  logic                 spi_do_d, cmd_error_d;
  logic                 load, load_d, rd_cmd, rd_cmd_d;
  logic                 advance_c, mem_we_c, mem_re_c;
  logic [7:0]           rd_data;
  logic [7:0]           mem [DEPTH];

  // Next address for page (wrap inside page) and sequential (wrap whole array) modes.
  always_comb begin
    addr_inc_c = addr;
    advance_c  = 1'b0;
    case (status[7:6])
      MODE_PAGE: begin
        addr_inc_c[PAGE_BITS-1:0] = addr[PAGE_BITS-1:0] + PAGE_BITS'(1);
        advance_c = 1'b1;
      end
      MODE_SEQ: begin
        addr_inc_c = addr + ADDR_BITS'(1);
        advance_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and datapath decode; cs_n deassertion overrides everything.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    rx_d        = rx;
    tx_d        = tx;
    addr_d      = addr;
    status_d    = status;
    spi_do_d    = spi_do;
    cmd_error_d = 1'b0;
    load_d      = 1'b0;
    rd_cmd_d    = rd_cmd;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    rx_n_c      = {rx, di_s};

    if (cs_rise_c) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      if (sclk_rise_c && state != IDLE && state != IGNORE) begin
        rx_d      = rx_n_c[ADDR_BITS-2:0];
        bit_cnt_d = bit_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end
        CMD: begin
          if (sclk_rise_c && bit_cnt == LAST_BYTE_BIT) begin
            bit_cnt_d = '0;
            case (rx_n_c[7:0])
              CMD_READ:  begin state_d = ADDR; rd_cmd_d = 1'b1; end
              CMD_WRITE: begin state_d = ADDR; rd_cmd_d = 1'b0; end
              CMD_RDSR:  begin state_d = RD_STAT; tx_d = status; end
              CMD_WRSR:  state_d = WR_STAT;
              default: begin
                state_d     = IGNORE;
                cmd_error_d = 1'b1;
              end
            endcase
          end
        end
        ADDR: begin
          if (sclk_rise_c && bit_cnt == LAST_ADDR_BIT) begin
            bit_cnt_d = '0;
            addr_d    = rx_n_c;
            if (rd_cmd) begin
              state_d  = RD_DATA;
              mem_re_c = 1'b1;
              load_d   = 1'b1;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (load) tx_d = rd_data;
          if (sclk_fall_c) begin
            spi_do_d = tx[7];
            tx_d     = {tx[6:0], 1'b0};
          end
          if (sclk_rise_c && bit_cnt == LAST_BYTE_BIT) begin
            bit_cnt_d = '0;
            if (advance_c) begin
              addr_d   = addr_inc_c;
              mem_re_c = 1'b1;
              load_d   = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        WR_DATA: begin
          if (sclk_rise_c && bit_cnt == LAST_BYTE_BIT) begin
            bit_cnt_d = '0;
            mem_we_c  = 1'b1;
            if (advance_c) addr_d = addr_inc_c;
            else           state_d = IGNORE;
          end
        end
        RD_STAT: begin
          if (sclk_fall_c) begin
            spi_do_d = tx[7];
            tx_d     = {tx[6:0], tx[7]};
          end
        end
        WR_STAT: begin
          if (sclk_rise_c && bit_cnt == LAST_BYTE_BIT) begin
            status_d = {rx_n_c[7:6], 5'b0, rx_n_c[0]};
            state_d  = IGNORE;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != RD_DATA && state_d != RD_STAT) spi_do_d = 1'b0;
    mem_addr_c = mem_we_c ? addr : addr_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      addr      <= '0;
      status    <= 8'h00;
      spi_do    <= 1'b0;
      cmd_error <= 1'b0;
      active    <= 1'b0;
      load      <= 1'b0;
      rd_cmd    <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      rx        <= rx_d;
      tx        <= tx_d;
      addr      <= addr_d;
      status    <= status_d;
      spi_do    <= spi_do_d;
      cmd_error <= cmd_error_d;
      active    <= ~cs_n_s;
      load      <= load_d;
      rd_cmd    <= rd_cmd_d;
    end
  end

  // Single-port byte array with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= rx_n_c[7:0];
    if (mem_re_c) rd_data <= mem[mem_addr_c];
  end

endmodule

// File: tb/tb_mkmif_sram_slave.sv
// Directed bench for the serial SRAM slave, driving it as a mode-0 SPI master.
module tb_mkmif_sram_slave;
  import mkmif_pkg::*;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_di = 1'b0;
  logic       spi_do;
  logic [7:0] status;
  logic       active;
  logic       cmd_error;

  int tests = 0;
  int fails = 0;
  int err_cycles = 0;
  int do_high_cycles = 0;

  mkmif_sram_slave dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_di    (spi_di),
    .spi_do    (spi_do),
    .status    (status),
    .active    (active),
    .cmd_error (cmd_error)
  );

  always #5 clk = ~clk;

  // Running counts of cmd_error-high and spi_do-high cycles.
  always @(posedge clk) begin
    if (cmd_error === 1'b1) err_cycles++;
    if (spi_do === 1'b1) do_high_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_di = txb[i];
      wait_clk(HALF);
      rxb[i] = spi_do;
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a);
    logic [7:0] d;
    xfer(cmd, 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  // Bytes are right-aligned in data; the first byte sent is the most significant one used.
  task automatic do_write(input logic [15:0] a, input logic [31:0] data, input int n);
    logic [7:0] d;
    cs_begin();
    send_hdr(CMD_WRITE, a);
    for (int k = 0; k < n; k++) xfer(data[8*(n-1-k) +: 8], 8, d);
    cs_end();
  endtask

  task automatic do_read(input logic [15:0] a, input int n, output logic [31:0] got);
    logic [7:0] d;
    got = '0;
    cs_begin();
    send_hdr(CMD_READ, a);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, d);
      got = (got << 8) | 32'(d);
    end
    cs_end();
  endtask

  task automatic wrsr(input logic [7:0] v);
    logic [7:0] d;
    cs_begin();
    xfer(CMD_WRSR, 8, d);
    xfer(v, 8, d);
    cs_end();
  endtask

  initial begin
    logic [7:0]  r;
    logic [31:0] got;
    logic [31:0] acc;
    int          e0;
    int          h0;

    // Reset values
    wait_clk(4);
    check("rst_spi_do", 32'(spi_do), 32'h0);
    check("rst_status", 32'(status), 32'h00);
    check("rst_active", 32'(active), 32'h0);
    check("rst_cmd_error", 32'(cmd_error), 32'h0);
    reset_n = 1'b1;
    wait_clk(4);
    e0 = err_cycles;

    // WRSR then RDSR
    wrsr(8'h41);
    check("wrsr_41", 32'(status), 32'h41);
    cs_begin();
    check("active_low_cs", 32'(active), 32'h1);
    xfer(CMD_RDSR, 8, r);
    xfer(8'h00, 8, r);
    check("rdsr_byte0", 32'(r), 32'h41);
    xfer(8'h00, 8, r);
    check("rdsr_repeat", 32'(r), 32'h41);
    cs_end();
    check("rdsr_do_idle", 32'(spi_do), 32'h0);
    check("no_cmd_error", 32'(err_cycles - e0), 32'h0);

    // Sequential write/read
    do_write(16'h0010, 32'hDEADBEEF, 4);
    do_read(16'h0010, 4, got);
    check("seq_read", got, 32'hDEADBEEF);

    // Page mode wrap
    wrsr(8'h80);
    check("wrsr_80", 32'(status), 32'h80);
    do_write(16'h003E, 32'h11223344, 4);
    do_read(16'h003E, 4, got);
    check("page_read_wrap", got, 32'h11223344);
    wrsr(8'h7F);
    check("wrsr_mask", 32'(status), 32'h41);
    do_read(16'h0020, 2, got);
    check("page_mem_20", got, 32'h3344);
    do_read(16'h003E, 2, got);
    check("page_mem_3e", got, 32'h1122);

    // Sequential wrap and upper address bits ignored
    do_write(16'h1FFF, 32'h0000A55A, 2);
    do_read(16'hFFFF, 2, got);
    check("seq_wrap_ffff", got, 32'hA55A);
    do_read(16'h0000, 1, got);
    check("seq_wrap_0000", got, 32'h5A);

    // Byte mode: only one data byte per transaction
    wrsr(8'h00);
    check("wrsr_00", 32'(status), 32'h00);
    do_write(16'h0010, 32'h00001234, 2);
    do_read(16'h0010, 2, got);
    check("byte_mode_read", got, 32'h1200);
    wrsr(8'h40);
    do_read(16'h0010, 2, got);
    check("byte_mode_write", got, 32'h12AD);

    // Abort mid-byte
    do_write(16'h0100, 32'h00000077, 1);
    cs_begin();
    send_hdr(CMD_WRITE, 16'h0100);
    xfer(8'hFF, 5, r);
    cs_end();
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_spi_do", 32'(spi_do), 32'h0);
    check("abort_active", 32'(active), 32'h0);
    do_read(16'h0100, 1, got);
    check("abort_mem", got, 32'h77);

    // Unsupported command
    e0 = err_cycles;
    h0 = do_high_cycles;
    acc = '0;
    cs_begin();
    xfer(8'hFF, 8, r);
    for (int k = 0; k < 3; k++) begin
      xfer(8'hFF, 8, r);
      acc = (acc << 8) | 32'(r);
    end
    cs_end();
    check("bad_cmd_rx", acc, 32'h0);
    check("bad_cmd_pulse", 32'(err_cycles - e0), 32'h1);
    check("bad_cmd_do_low", 32'(do_high_cycles - h0), 32'h0);
    check("bad_cmd_status", 32'(status), 32'h40);
    do_read(16'h0010, 4, got);
    check("bad_cmd_mem", got, 32'h12ADBEEF);
    do_read(16'h0100, 1, got);
    check("bad_cmd_mem100", got, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
